// File: rtl/zigzag_rle_pkg.sv
// zigzag_rle_pkg
// Shared definitions for the zigzag run-length encoder:
//   state_t        encoder FSM states
//   KIND_RUN/LIT   value of the token kind bit (run/EOB vs literal)
//   EOB_PAYLOAD    payload carried by the end-of-block token
//   pack_token()   places the kind bit directly above a COEF_W-bit payload
package zigzag_rle_pkg;

    // Widest coefficient the token packer can handle
    localparam int TOKEN_MAX_W = 32;

    localparam logic KIND_RUN = 1'b1;
    localparam logic KIND_LIT = 1'b0;

    // EOB is a run-kind token with a zero count, which a real run never has
    localparam logic [TOKEN_MAX_W-1:0] EOB_PAYLOAD = '0;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SCAN,
        ST_RUNOUT,
        ST_FLUSH,
        ST_EOB
    } state_t;

    // Payload must already be zero-extended; the caller truncates the
    // result down to coef_w+1 bits.
    function automatic logic [TOKEN_MAX_W:0] pack_token(
        input logic                   kind,
        input logic [TOKEN_MAX_W-1:0] payload,
        input int                     coef_w
    );
        logic [TOKEN_MAX_W:0] kind_bit;
        kind_bit = {{TOKEN_MAX_W{1'b0}}, kind} << coef_w;
        return {1'b0, payload} | kind_bit;
    endfunction

endpackage

// File: rtl/zigzag_walker.sv
// zigzag_walker
// Row/column walker that visits an N x N block in zigzag order.
// Ports:
//   Clock, reset_n   clock, asynchronous active-low reset
//   clear            return to (0,0)
//   step             advance to the next zigzag position
//   row, col         current position
//   last             high at the final position (N-1, N-1)
module zigzag_walker #(
    parameter int N = 8,
    localparam int R_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic           Clock,
    input  logic           reset_n,
    input  logic           clear,
    input  logic           step,
    output logic [R_W-1:0] row,
    output logic [R_W-1:0] col,
    output logic           last
);

    localparam logic [R_W-1:0] EDGE = R_W'(N - 1);

    assign last = (row == EDGE) && (col == EDGE);

    // Even anti-diagonals move up-right, odd ones move down-left; on
    // hitting an edge the walker slides along it onto the next diagonal.
    // Stepping is frozen at the last position so the counters never wrap.
    always_ff @(posedge Clock or negedge reset_n) begin
        if (!reset_n) begin
            row <= '0;
            col <= '0;
        end else if (clear) begin
            row <= '0;
            col <= '0;
        end else if (step && !last) begin
            if ((row[0] ^ col[0]) == 1'b0) begin
                if (col == EDGE) begin
                    row <= row + R_W'(1);
                end else if (row == '0) begin
                    col <= col + R_W'(1);
                end else begin
                    row <= row - R_W'(1);
                    col <= col + R_W'(1);
                end
            end else begin
                if (row == EDGE) begin
                    col <= col + R_W'(1);
                end else if (col == '0) begin
                    row <= row + R_W'(1);
                end else begin
                    row <= row + R_W'(1);
                    col <= col - R_W'(1);
                end
            end
        end
    end

endmodule

// File: rtl/zigzag_rle_encoder.sv
// zigzag_rle_encoder
// Captures an N x N block of coefficients, scans it in zigzag order and
// streams run / literal / end-of-block tokens over valid/ready.
// Ports:
//   Clock, reset_n   clock, asynchronous active-low reset
//   start, eob_en    capture request and trailing-zero fold mode
//   blk_in           raster block, coefficient k at [k*COEF_W +: COEF_W]
//   out_valid/ready  token handshake
//   out_token        {kind, payload}; kind 1 = run/EOB, 0 = literal
//   out_last         marks the EOB token
//   busy, done       block in progress / one-cycle completion pulse
module zigzag_rle_encoder
    import zigzag_rle_pkg::*;
#(
    parameter int N       = 8,
    parameter int COEF_W  = 8,
    parameter int RUN_MAX = 2**COEF_W - 1
) (
    input  logic                  Clock,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic                  eob_en,
    input  logic [N*N*COEF_W-1:0] blk_in,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [COEF_W:0]       out_token,
    output logic                  out_last,
    output logic                  busy,
    output logic                  done
);

    localparam int R_W   = (N > 1) ? $clog2(N) : 1;
    localparam int K_W   = (N > 1) ? $clog2(N * N) : 1;
    localparam int TOK_W = COEF_W + 1;

    state_t              state;
    logic [COEF_W-1:0]   blk_q [N*N];
    logic                eob_q;
    logic [COEF_W-1:0]   run_cnt;
    logic [COEF_W-1:0]   run_next;
    logic [COEF_W-1:0]   coef;
    logic [R_W-1:0]      row;
    logic [R_W-1:0]      col;
    logic [K_W-1:0]      cur_idx;
    logic                last_pos;
    logic                out_free;
    logic                capture;
    logic                walk_step;

    zigzag_walker #(.N(N)) u_walker (
        .Clock   (Clock),
        .reset_n (reset_n),
        .clear   (capture),
        .step    (walk_step),
        .row     (row),
        .col     (col),
        .last    (last_pos)
    );

    // The output register can take a new token when empty or being drained
    // this cycle. The walker advances on every zero and on every literal
    // actually sent; a literal preceded by a run waits one slot in RUNOUT.
    always_comb begin
        out_free  = !out_valid || out_ready;
        capture   = (state == ST_IDLE) && start;
        cur_idx   = K_W'(row) * K_W'(N) + K_W'(col);
        coef      = blk_q[cur_idx];
        run_next  = run_cnt + COEF_W'(1);
        walk_step = 1'b0;
        if (out_free) begin
            if (state == ST_SCAN) begin
                walk_step = (coef == '0) || (run_cnt == '0);
            end else if (state == ST_RUNOUT) begin
                walk_step = 1'b1;
            end
        end
    end

    // Block storage is pure data, so it carries no reset.
    always_ff @(posedge Clock) begin
        if (capture) begin
            for (int i = 0; i < N * N; i++) begin
                blk_q[i] <= blk_in[i*COEF_W +: COEF_W];
            end
        end
    end

    // Main FSM. Each state only acts when the output register is free, so a
    // stalled token stays put and the scan freezes with it.
    always_ff @(posedge Clock or negedge reset_n) begin
        if (!reset_n) begin
            state     <= ST_IDLE;
            eob_q     <= 1'b0;
            run_cnt   <= '0;
            out_valid <= 1'b0;
            out_token <= '0;
            out_last  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        eob_q   <= eob_en;
                        run_cnt <= '0;
                        busy    <= 1'b1;
                        state   <= ST_SCAN;
                    end
                end

                ST_SCAN: begin
                    if (out_free) begin
                        out_valid <= 1'b0;
                        out_last  <= 1'b0;
                        if (coef == '0) begin
                            if (run_next == COEF_W'(RUN_MAX)) begin
                                out_valid <= 1'b1;
                                out_token <= TOK_W'(pack_token(KIND_RUN, TOKEN_MAX_W'(run_next), COEF_W));
                                run_cnt   <= '0;
                            end else begin
                                run_cnt <= run_next;
                            end
                            if (last_pos) state <= ST_FLUSH;
                        end else if (run_cnt == '0) begin
                            out_valid <= 1'b1;
                            out_token <= TOK_W'(pack_token(KIND_LIT, TOKEN_MAX_W'(coef), COEF_W));
                            if (last_pos) state <= ST_FLUSH;
                        end else begin
                            out_valid <= 1'b1;
                            out_token <= TOK_W'(pack_token(KIND_RUN, TOKEN_MAX_W'(run_cnt), COEF_W));
                            run_cnt   <= '0;
                            state     <= ST_RUNOUT;
                        end
                    end
                end

                ST_RUNOUT: begin
                    if (out_free) begin
                        out_valid <= 1'b1;
                        out_last  <= 1'b0;
                        out_token <= TOK_W'(pack_token(KIND_LIT, TOKEN_MAX_W'(coef), COEF_W));
                        state     <= last_pos ? ST_FLUSH : ST_SCAN;
                    end
                end

                // A leftover run is either sent or dropped; when nothing is
                // sent the EOB goes out immediately to avoid a bubble.
                ST_FLUSH: begin
                    if (out_free) begin
                        out_valid <= 1'b1;
                        run_cnt   <= '0;
                        state     <= ST_EOB;
                        if ((run_cnt != '0) && !eob_q) begin
                            out_last  <= 1'b0;
                            out_token <= TOK_W'(pack_token(KIND_RUN, TOKEN_MAX_W'(run_cnt), COEF_W));
                        end else begin
                            out_last  <= 1'b1;
                            out_token <= TOK_W'(pack_token(KIND_RUN, EOB_PAYLOAD, COEF_W));
                        end
                    end
                end

                ST_EOB: begin
                    if (out_valid && out_last) begin
                        if (out_ready) begin
                            out_valid <= 1'b0;
                            out_last  <= 1'b0;
                            busy      <= 1'b0;
                            done      <= 1'b1;
                            state     <= ST_IDLE;
                        end
                    end else if (out_free) begin
                        out_valid <= 1'b1;
                        out_last  <= 1'b1;
                        out_token <= TOK_W'(pack_token(KIND_RUN, EOB_PAYLOAD, COEF_W));
                    end
                end

                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_zigzag_rle_encoder.sv
// tb_zigzag_rle_encoder
// Self-checking bench: an 8x8 / 8-bit encoder checked against a zigzag
// run-length reference model, plus an 8x8 / 4-bit encoder for run splitting.
module tb_zigzag_rle_encoder;

    logic         Clock = 1'b0;
    logic         reset_n;
    logic         start, eob_en, out_ready;
    logic [511:0] blk_in;
    logic         out_valid, out_last, busy, done;
    logic [8:0]   out_token;

    logic         start4, eob_en4, out_ready4;
    logic [255:0] blk_in4;
    logic         out_valid4, out_last4, busy4, done4;
    logic [4:0]   out_token4;

    int unsigned  total_cnt = 0;
    int unsigned  bad_cnt   = 0;
    int           exp_q[$];
    logic [8:0]   got_q[$];
    int           bubbles;
    int           loop_cycles;

    always #5 Clock = ~Clock;

    zigzag_rle_encoder #(.N(8), .COEF_W(8)) dut (
        .Clock(Clock), .reset_n(reset_n), .start(start), .eob_en(eob_en),
        .blk_in(blk_in), .out_valid(out_valid), .out_ready(out_ready),
        .out_token(out_token), .out_last(out_last), .busy(busy), .done(done)
    );

    zigzag_rle_encoder #(.N(8), .COEF_W(4)) dut4 (
        .Clock(Clock), .reset_n(reset_n), .start(start4), .eob_en(eob_en4),
        .blk_in(blk_in4), .out_valid(out_valid4), .out_ready(out_ready4),
        .out_token(out_token4), .out_last(out_last4), .busy(busy4), .done(done4)
    );

    // Reference: visit anti-diagonals (odd ones top-down, even ones
    // bottom-up), count zeros between nonzero values, split each zero count
    // into full rm-sized runs plus a remainder. Trailing remainder is dropped
    // when eob is set; full runs were already emitted during the scan.
    function automatic void build_expected(input logic [511:0] blk, input bit eob,
                                           input int w, input int rm);
        int zeros, lo, hi, r, k, v;
        logic [511:0] tmp;
        exp_q.delete();
        zeros = 0;
        for (int s = 0; s < 15; s++) begin
            lo = (s > 7) ? s - 7 : 0;
            hi = (s < 7) ? s : 7;
            for (int j = 0; j <= hi - lo; j++) begin
                r   = (s % 2 == 1) ? lo + j : hi - j;
                k   = r * 8 + (s - r);
                tmp = blk >> (k * w);
                v   = int'(tmp[7:0]) & ((1 << w) - 1);
                if (v == 0) begin
                    zeros++;
                end else begin
                    for (int q = 0; q < zeros / rm; q++) exp_q.push_back((1 << w) | rm);
                    if (zeros % rm != 0) exp_q.push_back((1 << w) | (zeros % rm));
                    exp_q.push_back(v);
                    zeros = 0;
                end
            end
        end
        for (int q = 0; q < zeros / rm; q++) exp_q.push_back((1 << w) | rm);
        if (!eob && (zeros % rm != 0)) exp_q.push_back((1 << w) | (zeros % rm));
        exp_q.push_back(1 << w);
    endfunction

    function automatic logic [511:0] random_block();
        logic [511:0] b;
        b = '0;
        for (int k = 0; k < 64; k++) begin
            if ($urandom_range(0, 2) == 0) b[k*8 +: 8] = 8'($urandom_range(1, 255));
        end
        return b;
    endfunction

    // Drives one block through the 8-bit encoder and collects accepted
    // tokens into got_q. poke_at >= 0 re-asserts start with a different
    // block at that loop cycle, while the encoder is busy.
    task automatic run_block(input logic [511:0] blk, input bit eob,
                             input bit rand_ready, input int poke_at);
        bit         hold, fin;
        logic [8:0] held_tok;
        logic       held_last;
        got_q.delete();
        bubbles = 0; loop_cycles = 0; hold = 0; fin = 0;
        held_tok = '0; held_last = 1'b0;
        @(negedge Clock);
        blk_in = blk; eob_en = eob; start = 1'b1; out_ready = 1'b0;
        @(negedge Clock);
        start = 1'b0;
        total_cnt++;
        if (busy !== 1'b1) begin
            bad_cnt++; $display("[TB] FAIL busy_after_start got=%b want=1", busy);
        end
        total_cnt++;
        if (out_valid !== 1'b0) begin
            bad_cnt++; $display("[TB] FAIL first_token_latency valid=%b want=0", out_valid);
        end
        while (!fin && loop_cycles < 3000) begin
            @(negedge Clock);
            loop_cycles++;
            start = 1'b0;
            if (loop_cycles == poke_at) begin
                start  = 1'b1;
                blk_in = ~blk;
                eob_en = ~eob;
            end
            if (hold) begin
                total_cnt++;
                if (out_valid !== 1'b1 || out_token !== held_tok || out_last !== held_last) begin
                    bad_cnt++;
                    $display("[TB] FAIL stall_hold got=%b/%h/%b want=1/%h/%b",
                             out_valid, out_token, out_last, held_tok, held_last);
                end
            end
            if (out_valid !== 1'b1) bubbles++;
            out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            if (out_valid === 1'b1 && out_ready) begin
                got_q.push_back(out_token);
                total_cnt++;
                if (out_last !== (out_token == 9'h100)) begin
                    bad_cnt++;
                    $display("[TB] FAIL last_flag tok=%h last=%b", out_token, out_last);
                end
                if (out_last === 1'b1) fin = 1;
            end
            hold      = (out_valid === 1'b1) && !out_ready;
            held_tok  = out_token;
            held_last = out_last;
        end
        start = 1'b0;
        out_ready = 1'b1;
        if (!fin) begin
            total_cnt++; bad_cnt++;
            $display("[TB] FAIL eob_timeout got=%0d tokens want=EOB", got_q.size());
        end else begin
            @(negedge Clock);
            total_cnt++;
            if (done !== 1'b1 || busy !== 1'b0) begin
                bad_cnt++; $display("[TB] FAIL done_pulse done=%b busy=%b want=1/0", done, busy);
            end
            @(negedge Clock);
            total_cnt++;
            if (done !== 1'b0) begin
                bad_cnt++; $display("[TB] FAIL done_width done=%b want=0", done);
            end
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        start = 0; eob_en = 0; out_ready = 1; blk_in = '0;
        start4 = 0; eob_en4 = 0; out_ready4 = 1; blk_in4 = '0;
        repeat (3) @(negedge Clock);
        total_cnt++;
        if ({out_valid, out_token, out_last, busy, done} !== 13'b0) begin
            bad_cnt++;
            $display("[TB] FAIL reset_values got=%b/%h/%b/%b/%b want=all 0",
                     out_valid, out_token, out_last, busy, done);
        end
        reset_n = 1'b1;
        repeat (2) @(negedge Clock);
        total_cnt++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
            bad_cnt++;
            $display("[TB] FAIL idle_after_reset got=%b/%b/%b want=0/0/0", out_valid, busy, done);
        end
    endtask

    task automatic test_all_ones();
        logic [511:0] b;
        for (int k = 0; k < 64; k++) b[k*8 +: 8] = 8'h01;
        run_block(b, 1'b0, 1'b0, -1);
        total_cnt++;
        if (got_q.size() != 65) begin
            bad_cnt++; $display("[TB] FAIL ones_count got=%0d want=65", got_q.size());
        end
        foreach (got_q[i]) begin
            total_cnt++;
            if (got_q[i] !== ((i < 64) ? 9'h001 : 9'h100)) begin
                bad_cnt++; $display("[TB] FAIL ones_token[%0d] got=%h", i, got_q[i]);
            end
        end
        total_cnt++;
        if (bubbles != 0 || loop_cycles != 65) begin
            bad_cnt++;
            $display("[TB] FAIL ones_throughput bubbles=%0d cycles=%0d want=0/65", bubbles, loop_cycles);
        end
    endtask

    task automatic test_corner_literals();
        logic [511:0] b;
        logic [8:0]   want[4];
        want = '{9'h005, 9'h13E, 9'h0FD, 9'h100};
        b = '0;
        b[7:0]     = 8'd5;
        b[511:504] = 8'hFD;
        run_block(b, 1'b0, 1'b0, -1);
        total_cnt++;
        if (got_q.size() != 4) begin
            bad_cnt++; $display("[TB] FAIL corner_count got=%0d want=4", got_q.size());
        end
        for (int i = 0; i < 4 && i < got_q.size(); i++) begin
            total_cnt++;
            if (got_q[i] !== want[i]) begin
                bad_cnt++; $display("[TB] FAIL corner_token[%0d] got=%h want=%h", i, got_q[i], want[i]);
            end
        end
    endtask

    task automatic test_all_zero();
        run_block('0, 1'b1, 1'b0, -1);
        total_cnt++;
        if (got_q.size() != 1 || got_q[0] !== 9'h100) begin
            bad_cnt++; $display("[TB] FAIL zero_eob_fold got=%0d tokens first=%h want=1 token 100",
                                got_q.size(), (got_q.size() > 0) ? got_q[0] : 9'h0);
        end
        run_block('0, 1'b0, 1'b0, -1);
        total_cnt++;
        if (got_q.size() != 2 || got_q[0] !== 9'h140 || got_q[1] !== 9'h100) begin
            bad_cnt++; $display("[TB] FAIL zero_run64 got=%0d tokens first=%h want=140,100",
                                got_q.size(), (got_q.size() > 0) ? got_q[0] : 9'h0);
        end
    endtask

    task automatic test_narrow_coef();
        logic [4:0] got4[$];
        logic [4:0] want4[6];
        bit         fin;
        want4 = '{5'h1F, 5'h1F, 5'h1F, 5'h1F, 5'h14, 5'h10};
        fin = 0;
        @(negedge Clock);
        blk_in4 = '0; eob_en4 = 1'b0; out_ready4 = 1'b1; start4 = 1'b1;
        @(negedge Clock);
        start4 = 1'b0;
        for (int c = 0; c < 500 && !fin; c++) begin
            @(negedge Clock);
            if (out_valid4 === 1'b1) begin
                got4.push_back(out_token4);
                if (out_last4 === 1'b1) fin = 1;
            end
        end
        total_cnt++;
        if (got4.size() != 6) begin
            bad_cnt++; $display("[TB] FAIL narrow_count got=%0d want=6", got4.size());
        end
        for (int i = 0; i < 6 && i < got4.size(); i++) begin
            total_cnt++;
            if (got4[i] !== want4[i]) begin
                bad_cnt++; $display("[TB] FAIL narrow_token[%0d] got=%h want=%h", i, got4[i], want4[i]);
            end
        end
    endtask

    task automatic test_random_stall();
        logic [511:0] b;
        bit           eob;
        for (int t = 0; t < 4; t++) begin
            b   = random_block();
            eob = 1'($urandom_range(0, 1));
            build_expected(b, eob, 8, 255);
            for (int pass = 0; pass < 2; pass++) begin
                run_block(b, eob, pass == 1, -1);
                total_cnt++;
                if (got_q.size() != exp_q.size()) begin
                    bad_cnt++;
                    $display("[TB] FAIL rand_len blk%0d pass%0d got=%0d want=%0d",
                             t, pass, got_q.size(), exp_q.size());
                end
                foreach (exp_q[i]) begin
                    if (i < got_q.size()) begin
                        total_cnt++;
                        if (got_q[i] !== 9'(exp_q[i])) begin
                            bad_cnt++;
                            $display("[TB] FAIL rand_token blk%0d pass%0d [%0d] got=%h want=%h",
                                     t, pass, i, got_q[i], 9'(exp_q[i]));
                        end
                    end
                end
            end
        end
    endtask

    task automatic test_busy_start();
        logic [511:0] b;
        bit           saw;
        b = random_block();
        b[7:0] = 8'h33;
        build_expected(b, 1'b0, 8, 255);
        run_block(b, 1'b0, 1'b1, 6);
        total_cnt++;
        if (got_q.size() != exp_q.size()) begin
            bad_cnt++; $display("[TB] FAIL busy_start_len got=%0d want=%0d", got_q.size(), exp_q.size());
        end
        foreach (exp_q[i]) begin
            if (i < got_q.size()) begin
                total_cnt++;
                if (got_q[i] !== 9'(exp_q[i])) begin
                    bad_cnt++;
                    $display("[TB] FAIL busy_start_token[%0d] got=%h want=%h", i, got_q[i], 9'(exp_q[i]));
                end
            end
        end
        saw = 0;
        repeat (12) begin
            @(negedge Clock);
            if (out_valid !== 1'b0 || busy !== 1'b0) saw = 1;
        end
        total_cnt++;
        if (saw) begin
            bad_cnt++; $display("[TB] FAIL no_second_block got=active want=idle");
        end
    endtask

    task automatic test_reset_mid_block();
        logic [511:0] b;
        int           accepted;
        bit           saw;
        for (int k = 0; k < 64; k++) b[k*8 +: 8] = 8'h01;
        accepted = 0;
        @(negedge Clock);
        blk_in = b; eob_en = 1'b0; out_ready = 1'b1; start = 1'b1;
        @(negedge Clock);
        start = 1'b0;
        for (int c = 0; c < 200 && accepted < 10; c++) begin
            @(negedge Clock);
            if (out_valid === 1'b1) accepted++;
        end
        start   = 1'b1;
        reset_n = 1'b0;
        #1;
        total_cnt++;
        if (accepted != 10 || {out_valid, out_token, out_last, busy, done} !== 13'b0) begin
            bad_cnt++;
            $display("[TB] FAIL async_reset tokens=%0d got=%b/%h/%b/%b/%b want=10 and all 0",
                     accepted, out_valid, out_token, out_last, busy, done);
        end
        @(negedge Clock);
        start   = 1'b0;
        reset_n = 1'b1;
        saw = 0;
        repeat (20) begin
            @(negedge Clock);
            if (out_valid !== 1'b0 || busy !== 1'b0) saw = 1;
        end
        total_cnt++;
        if (saw) begin
            bad_cnt++; $display("[TB] FAIL idle_after_mid_reset got=active want=idle");
        end
    endtask

    initial begin
        test_reset();
        test_all_ones();
        test_corner_literals();
        test_all_zero();
        test_narrow_coef();
        test_random_stall();
        test_busy_start();
        test_reset_mid_block();
        $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
        $finish;
    end

endmodule
